// File: rtl/grf_pkg.sv
// grf_pkg: widths, arbiter state encoding and the
// buffered multiply/divide result entry for the GRF port.
package grf_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUEUED = 2'd1,
    FREEZE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              live;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } md_entry_t;

  function automatic logic [NREG-1:0] regOneHot(
    input logic [REG_W-1:0] r
  );
    logic [NREG-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/md_result_fifo.sv
// md_result_fifo: circular buffer of MD results with
// per-register kill, feeding the GRF write arbiter.
//
// Ports:
//   Clock, Reset       clock, async active-low reset
//   Push, PushEntry    enqueue (caller guarantees !Full)
//   Pop                dequeue head (caller guarantees !Empty)
//   KillEn, KillReg    clear live on entries writing KillReg
//   Head               oldest entry
//   Empty, Full, Count occupancy
//   LiveVec, RegVec    per-slot live bit and destination
module md_result_fifo
  import grf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Push,
  input  md_entry_t                  PushEntry,
  input  logic                       Pop,
  input  logic                       KillEn,
  input  logic [REG_W-1:0]           KillReg,
  output md_entry_t                  Head,
  output logic                       Empty,
  output logic                       Full,
  output logic [$clog2(DEPTH):0]     Count,
  output logic [DEPTH-1:0]           LiveVec,
  output logic [DEPTH-1:0][REG_W-1:0] RegVec
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  md_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;

  // Slots not holding a queued entry always carry
  // live=0, so LiveVec needs no occupancy mask.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      Count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (KillEn && mem[i].rd == KillReg) begin
          mem[i].live <= 1'b0;
        end
      end
      if (Pop) begin
        mem[rdPtr].live <= 1'b0;
        rdPtr           <= rdPtr + PTR_W'(1);
      end
      if (Push) begin
        mem[wrPtr] <= PushEntry;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      case ({Push, Pop})
        2'b10:   Count <= Count + CNT_W'(1);
        2'b01:   Count <= Count - CNT_W'(1);
        default: Count <= Count;
      endcase
    end
  end

  assign Head  = mem[rdPtr];
  assign Empty = (Count == '0);
  assign Full  = (Count == CNT_W'(DEPTH));

  always_comb begin
    LiveVec = '0;
    RegVec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      LiveVec[i] = mem[i].live;
      RegVec[i]  = mem[i].rd;
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the GRF write port between the
// WB stage (priority) and buffered MD results.
//
// Ports:
//   Clock, Reset              clock, async active-low reset
//   WbWrite/WbReg/WbData/WbPC WB write request
//   MdValid/MdReady           MD result handshake
//   MdReg/MdData/MdPC         MD result payload
//   WbFreeze                  one-cycle WB hold for MD
//   PendingMask               regs with live queued MD writes
//   RegWrite/WriteReg/
//   WriteData/WPC             GRF write port
module grf_wb_arbiter
  import grf_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              WbWrite,
  input  logic [REG_W-1:0]  WbReg,
  input  logic [DATA_W-1:0] WbData,
  input  logic [DATA_W-1:0] WbPC,
  input  logic              MdValid,
  output logic              MdReady,
  input  logic [REG_W-1:0]  MdReg,
  input  logic [DATA_W-1:0] MdData,
  input  logic [DATA_W-1:0] MdPC,
  output logic              WbFreeze,
  output logic [NREG-1:0]   PendingMask,
  output logic              RegWrite,
  output logic [REG_W-1:0]  WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] WPC
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM =
    WAIT_W'(MAX_WAIT - 1);

  arb_state_e        state;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] waitNext;
  logic              waitHit;

  logic              wbGrant;
  logic              mdGrant;
  logic              push;
  logic              killEn;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  countNext;
  md_entry_t         head;
  md_entry_t         pushEntry;

  logic [DEPTH-1:0]            liveVec;
  logic [DEPTH-1:0][REG_W-1:0] regVec;

  logic [REG_W-1:0]  holdReg;
  logic [DATA_W-1:0] holdData;
  logic [DATA_W-1:0] holdPc;

  // Register 0 results are queued but never write.
  assign pushEntry = '{
    live: (MdReg != '0),
    rd:   MdReg,
    data: MdData,
    pc:   MdPC
  };

  assign MdReady = !full;
  assign push    = MdValid && !full;

  // Reset gating keeps the GRF port quiet while the
  // reset is held, whatever WB presents.
  assign wbGrant = Reset && WbWrite && !WbFreeze;
  assign mdGrant = Reset && !wbGrant && !empty;

  // WB is younger than every queued entry, so a WB
  // write supersedes queued writes to the same reg.
  assign killEn  = wbGrant && (WbReg != '0);

  md_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .Push      (push),
    .PushEntry (pushEntry),
    .Pop       (mdGrant),
    .KillEn    (killEn),
    .KillReg   (WbReg),
    .Head      (head),
    .Empty     (empty),
    .Full      (full),
    .Count     (count),
    .LiveVec   (liveVec),
    .RegVec    (regVec)
  );

  assign countNext = count
                   + CNT_W'(push)
                   - CNT_W'(mdGrant);

  assign waitNext = waitCnt + WAIT_W'(1);
  assign waitHit  = !empty && !mdGrant
                 && (waitNext >= WAIT_LIM);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      WbFreeze <= 1'b0;
      waitCnt  <= '0;
    end else begin
      if (empty || mdGrant) begin
        waitCnt <= '0;
      end else begin
        waitCnt <= waitNext;
      end
      unique case (state)
        IDLE, QUEUED: begin
          if (waitHit) begin
            state    <= FREEZE;
            WbFreeze <= 1'b1;
          end else begin
            state    <= (countNext == '0) ? IDLE
                                          : QUEUED;
            WbFreeze <= 1'b0;
          end
        end
        FREEZE: begin
          state    <= (countNext == '0) ? IDLE
                                        : QUEUED;
          WbFreeze <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          WbFreeze <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    RegWrite  = 1'b0;
    WriteReg  = holdReg;
    WriteData = holdData;
    WPC       = holdPc;
    unique case (1'b1)
      wbGrant: begin
        RegWrite  = (WbReg != '0);
        WriteReg  = WbReg;
        WriteData = WbData;
        WPC       = WbPC;
      end
      mdGrant: begin
        RegWrite  = head.live;
        WriteReg  = head.rd;
        WriteData = head.data;
        WPC       = head.pc;
      end
      default: ;
    endcase
  end

  // Idle cycles present the last granted write.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      holdReg  <= '0;
      holdData <= '0;
      holdPc   <= '0;
    end else if (wbGrant || mdGrant) begin
      holdReg  <= WriteReg;
      holdData <= WriteData;
      holdPc   <= WPC;
    end
  end

  always_comb begin
    PendingMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (liveVec[i]) begin
        PendingMask = PendingMask
                    | regOneHot(regVec[i]);
      end
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter: directed and random stimulus against
// a queue-level model of the GRF write-port arbiter.
module tb_grf_wb_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        Clock;
  logic        Reset;
  logic        WbWrite;
  logic [4:0]  WbReg;
  logic [31:0] WbData;
  logic [31:0] WbPC;
  logic        MdValid;
  logic        MdReady;
  logic [4:0]  MdReg;
  logic [31:0] MdData;
  logic [31:0] MdPC;
  logic        WbFreeze;
  logic [31:0] PendingMask;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [31:0] WPC;

  grf_wb_arbiter #(
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .WbWrite     (WbWrite),
    .WbReg       (WbReg),
    .WbData      (WbData),
    .WbPC        (WbPC),
    .MdValid     (MdValid),
    .MdReady     (MdReady),
    .MdReg       (MdReg),
    .MdData      (MdData),
    .MdPC        (MdPC),
    .WbFreeze    (WbFreeze),
    .PendingMask (PendingMask),
    .RegWrite    (RegWrite),
    .WriteReg    (WriteReg),
    .WriteData   (WriteData),
    .WPC         (WPC)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit        live;
    bit [4:0]  rd;
    bit [31:0] data;
    bit [31:0] pc;
  } ent_t;

  ent_t      q[$];
  int        mWait;
  bit        mFreeze;
  bit [4:0]  lastReg;
  bit [31:0] lastData;
  bit [31:0] lastPc;
  bit        rstN;
  bit        accepted;
  bit        frozeNow;
  int        writesSeen [32];
  int        nTests;
  int        nFail;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h",
               tag, got, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mWait    = 0;
    mFreeze  = 0;
    lastReg  = '0;
    lastData = '0;
    lastPc   = '0;
  endtask

  // One clock cycle: drive at the falling edge, check
  // outputs 1ns later, then advance the model past the
  // following rising edge.
  task automatic step(
    input bit wbW, input bit [4:0] wbR,
    input bit [31:0] wbD, input bit [31:0] wbP,
    input bit mdV, input bit [4:0] mdR,
    input bit [31:0] mdD, input bit [31:0] mdP);
    bit        wbG, pop, eRw, eRdy, nxtFreeze;
    bit [4:0]  eReg;
    bit [31:0] eData, ePc, eMask;
    @(negedge Clock);
    Reset   = rstN;
    WbWrite = wbW;
    WbReg   = wbR;
    WbData  = wbD;
    WbPC    = wbP;
    MdValid = mdV;
    MdReg   = mdR;
    MdData  = mdD;
    MdPC    = mdP;
    #1;
    if (!rstN) modelReset();
    eRdy = (q.size() < DEPTH);
    wbG  = rstN && wbW && !mFreeze;
    pop  = rstN && !wbG && (q.size() > 0);
    if (wbG) begin
      eRw = (wbR != 0);
      eReg = wbR; eData = wbD; ePc = wbP;
    end else if (pop) begin
      eRw = q[0].live;
      eReg = q[0].rd; eData = q[0].data;
      ePc = q[0].pc;
    end else begin
      eRw = 0;
      eReg = lastReg; eData = lastData;
      ePc = lastPc;
    end
    eMask = '0;
    foreach (q[i]) if (q[i].live) eMask[q[i].rd] = 1'b1;
    chk("RegWrite", RegWrite, eRw);
    chk("WriteReg", WriteReg, eReg);
    chk("WriteData", WriteData, eData);
    chk("WPC", WPC, ePc);
    chk("MdReady", MdReady, eRdy);
    chk("WbFreeze", WbFreeze, mFreeze);
    chk("PendingMask", PendingMask, eMask);
    if (RegWrite === 1'b1) writesSeen[WriteReg]++;
    if (!rstN) begin
      accepted = 0;
      frozeNow = 0;
      return;
    end
    frozeNow = mFreeze;
    accepted = mdV && eRdy;
    if (wbG && wbR != 0)
      foreach (q[i]) if (q[i].rd == wbR) q[i].live = 0;
    nxtFreeze = 0;
    if (pop) begin
      void'(q.pop_front());
      mWait = 0;
    end else if (q.size() > 0) begin
      mWait++;
      if (mWait >= MAX_WAIT - 1) nxtFreeze = 1;
    end else begin
      mWait = 0;
    end
    if (accepted)
      q.push_back('{mdR != 0, mdR, mdD, mdP});
    if (wbG || pop) begin
      lastReg = eReg; lastData = eData; lastPc = ePc;
    end
    mFreeze = nxtFreeze;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic busy(input bit mdV, input bit [4:0] mdR,
                      input bit [31:0] mdD);
    step(1, 3, 32'hA, 32'h500, mdV, mdR, mdD, 32'h600);
  endtask

  initial begin
    bit        wbW, mdV;
    bit [4:0]  wbR, mdR;
    bit [31:0] wbD, wbP, mdD, mdP;
    int        k;
    nTests = 0;
    nFail  = 0;
    rstN   = 0;
    modelReset();
    Reset = 0; WbWrite = 0; WbReg = 0; WbData = 0;
    WbPC = 0; MdValid = 0; MdReg = 0; MdData = 0;
    MdPC = 0;
    foreach (writesSeen[i]) writesSeen[i] = 0;

    // reset held with traffic present
    repeat (3)
      step(1, 4, 32'h1, 32'h100, 1, 6, 32'h2, 32'h200);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_ready", MdReady, 1);
    chk("rst_mask", PendingMask, 0);
    rstN = 1;
    step(0, 0, 0, 0, 1, 5, 32'h11, 32'h400);
    idle(1);
    chk("md5_regwrite", RegWrite, 1);
    chk("md5_reg", WriteReg, 5);
    chk("md5_data", WriteData, 32'h11);
    chk("md5_mask_pre", PendingMask, 32'h20);
    idle(1);
    chk("md5_mask_post", PendingMask, 0);

    // WB priority and starvation freeze
    busy(1, 7, 32'h77);
    for (int c = 0; c < 3; c++) begin
      busy(0, 0, 0);
      chk("prio_wb_reg", WriteReg, 3);
      chk("prio_nofreeze", WbFreeze, 0);
    end
    busy(0, 0, 0);
    chk("prio_freeze", WbFreeze, 1);
    chk("prio_md_reg", WriteReg, 7);
    chk("prio_md_data", WriteData, 32'h77);
    busy(0, 0, 0);
    chk("prio_resume_reg", WriteReg, 3);
    chk("prio_resume_data", WriteData, 32'hA);
    chk("prio_resume_frz", WbFreeze, 0);
    idle(2);

    // WAW kill
    busy(1, 9, 32'hBB);
    step(1, 9, 32'hCC, 32'h704, 0, 0, 0, 0);
    chk("waw_mask_pre", PendingMask, 32'h200);
    busy(0, 0, 0);
    chk("waw_mask_post", PendingMask[9], 0);
    busy(0, 0, 0);
    busy(0, 0, 0);
    chk("waw_freeze", WbFreeze, 1);
    chk("waw_pop_reg", WriteReg, 9);
    chk("waw_pop_nowrite", RegWrite, 0);
    idle(2);

    // full buffer, third push held
    foreach (writesSeen[i]) writesSeen[i] = 0;
    busy(1, 10, 32'h1010);
    busy(1, 11, 32'h1111);
    busy(1, 12, 32'h1212);
    chk("full_ready", MdReady, 0);
    k = 0;
    while (!accepted && k < 10) begin
      busy(1, 12, 32'h1212);
      k++;
    end
    chk("full_push3_taken", accepted, 1);
    idle(8);
    chk("full_wr10", writesSeen[10], 1);
    chk("full_wr11", writesSeen[11], 1);
    chk("full_wr12", writesSeen[12], 1);

    // register zero
    step(1, 0, 32'h55, 32'h900, 0, 0, 0, 0);
    chk("zero_wb_nowrite", RegWrite, 0);
    step(0, 0, 0, 0, 1, 0, 32'h66, 32'h904);
    idle(1);
    chk("zero_md_mask", PendingMask, 0);
    chk("zero_md_nowrite", RegWrite, 0);
    chk("zero_md_data", WriteData, 32'h66);
    idle(1);

    // async reset with two entries queued
    busy(1, 20, 32'h2020);
    busy(1, 21, 32'h2121);
    writesSeen[20] = 0;
    writesSeen[21] = 0;
    busy(0, 0, 0);
    chk("arst_mask_pre", PendingMask, 32'h0030_0000);
    #2;
    WbWrite = 0;
    MdValid = 0;
    Reset   = 0;
    #1;
    chk("arst_mask", PendingMask, 0);
    chk("arst_ready", MdReady, 1);
    chk("arst_regwrite", RegWrite, 0);
    chk("arst_freeze", WbFreeze, 0);
    Reset = 1;
    modelReset();
    idle(6);
    chk("arst_no_writes",
        writesSeen[20] + writesSeen[21], 0);

    // random traffic
    wbW = 0; wbR = 0; wbD = 0; wbP = 0;
    mdV = 0; mdR = 0; mdD = 0; mdP = 0;
    accepted = 0;
    frozeNow = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!frozeNow) begin
        wbW = ($urandom_range(0, 99) < 60);
        wbR = ($urandom_range(0, 3) == 0)
            ? 5'($urandom) : 5'($urandom_range(0, 7));
        wbD = $urandom;
        wbP = $urandom;
      end
      if (!(mdV && !accepted)) begin
        mdV = ($urandom_range(0, 99) < 40);
        mdR = ($urandom_range(0, 3) == 0)
            ? 5'($urandom) : 5'($urandom_range(0, 7));
        mdD = $urandom;
        mdP = $urandom;
      end
      step(wbW, wbR, wbD, wbP, mdV, mdR, mdD, mdP);
    end

    $display("[TB] %0d tests run, %0d failed",
             nTests, nFail);
    $finish;
  end

endmodule
